// File: rtl/regfile_pkg.sv
// Shared sizing and types for the ARM64 register file, used by storage, dimension swap,
// read muxes and hazard logic.
package regfile_pkg;

  localparam int NUM_REGS_C   = 32;
  localparam int DATA_WIDTH_C = 64;
  localparam int ZERO_REG_C   = 31;

  typedef logic [4:0]  reg_idx_t;
  typedef logic [63:0] reg_word_t;

endpackage

// File: rtl/regfile_write_decoder.sv
// One-hot write-enable decoder; the hard-wired zero register never receives an enable.
module regfile_write_decoder #(
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 31
) (
  input  logic                        en,
  input  logic [$clog2(NUM_REGS)-1:0] idx,
  output logic [NUM_REGS-1:0]         sel
);

  localparam int IDX_W = $clog2(NUM_REGS);

  // An X on en propagates as X, which the storage treats as "no write".
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i != ZERO_REG) begin
        sel[i] = en & (idx == IDX_W'(i));
      end
    end
  end

endmodule

// File: rtl/regfile_storage.sv
// Architectural register storage: one write port, zero-register forcing and optional
// same-cycle write-through, exposing the whole image as an unpacked array.
module regfile_storage
  import regfile_pkg::*;
#(
  parameter int NUM_REGS   = NUM_REGS_C,
  parameter int DATA_WIDTH = DATA_WIDTH_C,
  parameter int ZERO_REG   = ZERO_REG_C,
  parameter int BYPASS     = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        RegWrite,
  input  logic [$clog2(NUM_REGS)-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0]       WriteData,
  output logic [DATA_WIDTH-1:0]       regArray [NUM_REGS],
  output logic [15:0]                 writeCount
);

  logic [DATA_WIDTH-1:0] store [NUM_REGS];
  logic [NUM_REGS-1:0]   sel;

  regfile_write_decoder #(
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG)
  ) u_decoder (
    .en  (RegWrite),
    .idx (WriteRegister),
    .sel (sel)
  );

  // An X enable evaluates false in the if-tests below, so state is left untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        store[i] <= '0;
      end
      writeCount <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (sel[i]) begin
          store[i] <= WriteData;
        end
      end
      if (|sel) begin
        writeCount <= writeCount + 16'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regArray[i] = store[i];
      if ((BYPASS != 0) && sel[i]) begin
        regArray[i] = WriteData;
      end
      if ((i == ZERO_REG) || !reset) begin
        regArray[i] = '0;
      end
    end
  end

  // Out of reset the write enable must always be a known value.
  assert property (@(posedge clk) disable iff (!reset) !$isunknown(RegWrite));

endmodule
